// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: queue entry layout, fetch FSM states and the NOP encoding.
package cpu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] NONE = (AW+1)'(0);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push_i && (count_q != FULL);
    assign do_pop_s  = pop_i && (count_q != NONE);

    // Storage, pointers and count; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= NONE;
        end else if (flush_i) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= NONE;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != NONE);
    assign count_o = count_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC, BOOT/RUN/FLUSH FSM, in-flight tag and credit-based issue into fetch_queue.
// Optional feature: define MISALIGN_CHECK_EN to fault on misaligned jump targets (adds port if_adef).
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        if_adef
`endif
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight_q;
    logic [CW-1:0] count_s;
    logic          q_valid_s;
    logic          jump_s;
    logic          pop_s;
    logic          credit_s;
    logic          issue_s;
    logic          push_s;
    logic          fetch_ok_s;
    logic [31:0]   target_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;

`ifdef MISALIGN_CHECK_EN
    logic halt_q;
    logic fault_pend_q;
    logic fault_push_s;
    logic target_bad_s;

    assign target_bad_s = is_misaligned(jump_target);
    assign target_s     = jump_target;
    assign fault_push_s = fault_pend_q && !jump_s;
    assign fetch_ok_s   = !halt_q;
`else
    logic unused_adef_s;

    assign unused_adef_s = head_s.adef;
    assign target_s      = jump_target & 32'hFFFF_FFFC;
    assign fetch_ok_s    = 1'b1;
`endif

    assign jump_s   = jump_en && (state_q != BOOT);
    assign pop_s    = q_valid_s && id_ready;
    // Queue slots plus the outstanding response are the credits; a same-cycle pop frees one.
    assign credit_s = ((count_s + CW'(inflight_q)) < CW'(QUEUE_DEPTH)) || pop_s;
    assign issue_s  = ((state_q == RUN) || (state_q == FLUSH)) && fetch_ok_s && credit_s && !jump_s;

    // Select what enters the queue: the memory response, or a synthetic fault entry.
    always_comb begin
        push_s            = inflight_q && !jump_s;
        push_entry_s.pc   = req_pc_q;
        push_entry_s.inst = imem_rdata;
        push_entry_s.adef = 1'b0;
`ifdef MISALIGN_CHECK_EN
        if (fault_push_s) begin
            push_s            = 1'b1;
            push_entry_s.pc   = fetch_pc_q;
            push_entry_s.inst = INST_NOP;
            push_entry_s.adef = 1'b1;
        end else begin
            push_s = inflight_q && !jump_s;
        end
`endif
    end

    // Fetch FSM with PC, request tag and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= 32'h0000_0000;
            inflight_q   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            halt_q       <= 1'b0;
            fault_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN, FLUSH: begin
                    if (jump_s) begin
                        state_q      <= FLUSH;
                        fetch_pc_q   <= target_s;
                        inflight_q   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                        halt_q       <= target_bad_s;
                        fault_pend_q <= target_bad_s;
`endif
                    end else begin
                        state_q    <= RUN;
                        inflight_q <= issue_s;
                        if (issue_s) begin
                            fetch_pc_q <= fetch_pc_q + PC_STEP;
                            req_pc_q   <= fetch_pc_q;
                        end
`ifdef MISALIGN_CHECK_EN
                        fault_pend_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (jump_s),
        .wdata_i (push_entry_s),
        .head_o  (head_s),
        .valid_o (q_valid_s),
        .count_o (count_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_q;
    assign if_valid  = q_valid_s;
    assign if_pc     = q_valid_s ? head_s.pc : 32'h0000_0000;
    assign if_inst   = q_valid_s ? head_s.inst : 32'h0000_0000;
`ifdef MISALIGN_CHECK_EN
    assign if_adef   = q_valid_s && head_s.adef;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: memory returns addr>>2, decode stream checked against a PC-sequence model.
module tb_pc_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready = 1'b0;
`ifdef MISALIGN_CHECK_EN
    logic        if_adef;
    logic        s_adef;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_req, s_valid, s_hs;
    logic [31:0] s_addr, s_pc, s_inst;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(2), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .jump_en(jump_en), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
`ifdef MISALIGN_CHECK_EN
        , .if_adef(if_adef)
`endif
    );

    // Synchronous instruction memory: word at byte address a holds a>>2, garbage when not read.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;
    end

    task automatic tick(input logic r, input logic jv, input logic [31:0] jt, input logic rdy);
        @(negedge clk);
        rst = r; jump_en = jv; jump_target = jt; id_ready = rdy;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
        s_pc = if_pc; s_inst = if_inst; s_hs = if_valid && rdy;
`ifdef MISALIGN_CHECK_EN
        s_adef = if_adef;
`endif
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        exp_pc = RST_PC;
    endtask

    // Runs n ticks with id_ready=1 and checks every accepted entry against the model.
    task automatic run_stream(input int n);
        for (int t = 0; t < n; t++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_hs) begin
                n_tests++;
                if (s_pc !== exp_pc || s_inst !== (exp_pc >> 2)) begin
                    n_fail++;
                    $display("FAIL stream: got pc=%h inst=%h, expected pc=%h inst=%h", s_pc, s_inst, exp_pc, exp_pc >> 2);
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 32'h0000_0500, 1'b1);
            n_tests++;
            if (s_req !== 1'b0 || s_valid !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got req=%b valid=%b pc=%h inst=%h, expected all 0", s_req, s_valid, s_pc, s_inst);
            end
        end
        tick(1'b0, 1'b1, 32'h0000_0500, 1'b0);
        n_tests++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL boot_no_req: got %b expected 0", s_req); end
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== RST_PC) begin
            n_fail++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", s_req, s_addr, RST_PC);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got valid=%b expected 0", s_valid); end
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== RST_PC || s_inst !== (RST_PC >> 2)) begin
            n_fail++; $display("FAIL first_valid: got valid=%b pc=%h inst=%h expected 1/%h/%h", s_valid, s_pc, s_inst, RST_PC, RST_PC >> 2);
        end
    endtask

    task automatic test_stream();
        int first = -1;
        int acc = 0;
        do_reset();
        for (int t = 1; t <= 40; t++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_valid && first < 0) first = t;
            if (s_hs) begin
                n_tests++;
                if (s_pc !== exp_pc || s_inst !== (exp_pc >> 2)) begin
                    n_fail++; $display("FAIL seq_stream: got pc=%h inst=%h expected pc=%h inst=%h", s_pc, s_inst, exp_pc, exp_pc >> 2);
                end
                exp_pc = exp_pc + 32'd4;
                acc++;
            end
        end
        n_tests++;
        if (first != 3) begin n_fail++; $display("FAIL first_valid_cycle: got %0d expected 3", first); end
        n_tests++;
        if (acc != 38) begin n_fail++; $display("FAIL no_gaps: got %0d accepted expected 38", acc); end
    endtask

    task automatic test_stall();
        do_reset();
        run_stream(6);
        for (int t = 0; t < 6; t++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            n_tests++;
            if (s_valid !== 1'b1 || s_pc !== exp_pc || s_inst !== (exp_pc >> 2) || s_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: got valid=%b pc=%h req=%b expected 1/%h/0", s_valid, s_pc, s_req, exp_pc);
            end
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== exp_pc + 32'd8) begin
            n_fail++; $display("FAIL stall_two_buffered: got req=%b addr=%h expected 1/%h", s_req, s_addr, exp_pc + 32'd8);
        end
        n_tests++;
        if (s_pc !== exp_pc) begin n_fail++; $display("FAIL stall_release: got %h expected %h", s_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        for (int t = 0; t < 6; t++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            n_tests++;
            if (s_valid !== 1'b1 || s_pc !== exp_pc) begin
                n_fail++; $display("FAIL stall_order: got valid=%b pc=%h expected 1/%h", s_valid, s_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_jump();
        do_reset();
        run_stream(6);
        tick(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        n_tests++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL jump_req_blocked: got %b expected 0", s_req); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL flush_cycle: got valid=%b req=%b addr=%h expected 0/1/100", s_valid, s_req, s_addr);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL stale_dropped: got valid=%b pc=%h expected 0", s_valid, s_pc); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0000_0100 || s_inst !== 32'h0000_0040) begin
            n_fail++; $display("FAIL jump_penalty: got valid=%b pc=%h inst=%h expected 1/100/40", s_valid, s_pc, s_inst);
        end
        exp_pc = 32'h0000_0104;
        run_stream(5);
    endtask

    task automatic test_double_jump();
        int first = -1;
        int acc = 0;
        do_reset();
        run_stream(6);
        tick(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        if (s_hs) begin
            n_tests++;
            if (s_pc !== exp_pc) begin n_fail++; $display("FAIL pop_on_jump: got %h expected %h", s_pc, exp_pc); end
        end
        tick(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        n_tests++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_fail++; $display("FAIL rejump_flush: got valid=%b req=%b expected 0/0", s_valid, s_req);
        end
        exp_pc = 32'h0000_0300;
        for (int t = 1; t <= 8; t++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (s_valid && first < 0) first = t;
            if (s_hs) begin
                n_tests++;
                if (s_pc !== exp_pc || s_inst !== (exp_pc >> 2)) begin
                    n_fail++; $display("FAIL latest_target: got pc=%h expected %h", s_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                acc++;
            end
        end
        n_tests++;
        if (first != 3 || acc != 6) begin
            n_fail++; $display("FAIL rejump_timing: got first=%0d acc=%0d expected 3/6", first, acc);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        run_stream(6);
        tick(1'b0, 1'b1, 32'h0000_0102, 1'b0);
        n_tests++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL misalign_jump_req: got %b expected 0", s_req); end
`ifdef MISALIGN_CHECK_EN
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL adef_no_req: got %b expected 0", s_req); end
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0000_0102 || s_inst !== 32'h0 || s_adef !== 1'b1) begin
            n_fail++; $display("FAIL adef_entry: got valid=%b pc=%h inst=%h adef=%b expected 1/102/0/1", s_valid, s_pc, s_inst, s_adef);
        end
        for (int t = 0; t < 4; t++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            n_tests++;
            if (s_req !== 1'b0) begin n_fail++; $display("FAIL adef_halt: got req=%b expected 0", s_req); end
        end
`else
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL align_force: got req=%b addr=%h expected 1/100", s_req, s_addr);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL align_stream: got valid=%b pc=%h expected 1/100", s_valid, s_pc);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        run_stream(8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got req=%b valid=%b pc=%h inst=%h expected all 0", imem_req, if_valid, if_pc, if_inst);
        end
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== RST_PC) begin
            n_fail++; $display("FAIL restart_req: got req=%b addr=%h expected 1/%h", s_req, s_addr, RST_PC);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== RST_PC) begin
            n_fail++; $display("FAIL restart_valid: got valid=%b pc=%h expected 1/%h", s_valid, s_pc, RST_PC);
        end
    endtask

    task automatic test_random();
        int          acc = 0;
        logic        rdy, jv;
        logic [31:0] tgt;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            rdy = ($urandom_range(0, 3) != 0);
            jv  = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
`ifdef MISALIGN_CHECK_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            tick(1'b0, jv, tgt, rdy);
            if (s_hs) begin
                n_tests++;
                if (s_pc !== exp_pc || s_inst !== (exp_pc >> 2)) begin
                    n_fail++; $display("FAIL random_stream: got pc=%h inst=%h expected pc=%h inst=%h", s_pc, s_inst, exp_pc, exp_pc >> 2);
                end
                exp_pc = exp_pc + 32'd4;
                acc++;
            end
            if (jv) begin
                n_tests++;
                if (s_req !== 1'b0) begin n_fail++; $display("FAIL random_jump_req: got %b expected 0", s_req); end
                exp_pc = tgt & 32'hFFFF_FFFC;
            end
        end
        n_tests++;
        if (acc < 80) begin n_fail++; $display("FAIL random_progress: got %0d accepted expected at least 80", acc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_double_jump();
        test_misalign();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
